// File: rtl/tick_sequencer_if.sv
// Handshake and serial-output bundle shared by the tick sequencer and its driver.
interface tick_sequencer_if #(
    parameter int unsigned DIV_W = 28,
    parameter int unsigned PAT_W = 16
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [4:0]       len;
    logic [DIV_W-1:0] div_max;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             slow_clk;

    // Driver side: issues requests, observes the serial stream.
    modport master (
        output start, abort, pattern, len, div_max,
        input  bit_out, bit_valid, busy, done, err, slow_clk
    );

    // Sequencer side.
    modport slave (
        input  start, abort, pattern, len, div_max,
        output bit_out, bit_valid, busy, done, err, slow_clk
    );
endinterface

// File: rtl/tick_sequencer.sv
// Tick-paced serial pattern player: emits up to PAT_W latched bits, MSB first,
// one bit per (div_max+1) cycles, with abort, reject-on-bad-length and a
// visual slow clock that toggles once per emitted tick.
module tick_sequencer #(
    parameter int unsigned DIV_W = 28,
    parameter int unsigned PAT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    tick_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             slow_q, slow_d;

    logic             tick;
    logic             len_ok;
    logic             last_bit;

    // Next-state and output decode; the pattern is kept as a left-shift register
    // so the bit to emit is always its MSB.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        idx_d       = idx_q;
        len_d       = len_q;
        pat_d       = pat_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        slow_d      = slow_q;

        tick     = (cnt_q == div_q);
        len_ok   = (bus.len != 5'd0) && (32'(bus.len) <= PAT_W);
        last_bit = (idx_q == (len_q - IDX_W'(1)));

        case (state_q)
            IDLE: begin
                slow_d = 1'b0;
                if (bus.start) begin
                    if (len_ok) begin
                        pat_d   = bus.pattern;
                        len_d   = bus.len;
                        div_d   = bus.div_max;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // Abort beats a coinciding tick: no bit, no done.
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    slow_d  = 1'b0;
                end else if (tick) begin
                    cnt_d       = '0;
                    bit_out_d   = pat_q[PAT_W-1];
                    pat_d       = pat_q << 1;
                    bit_valid_d = 1'b1;
                    idx_d       = idx_q + IDX_W'(1);
                    if (last_bit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        slow_d  = 1'b0;
                    end else begin
                        slow_d = ~slow_q;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            pat_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            slow_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            pat_q       <= pat_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            slow_q      <= slow_d;
        end
    end

    // Drive the bundle straight from the registers.
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.slow_clk  = slow_q;
endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: a cycle-by-cycle vector table plus
// hand-written multi-cycle sequences for timing, abort and reset corners.
module tb_tick_sequencer;
    localparam int unsigned DIV_W = 28;
    localparam int unsigned PAT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tick_sequencer_if #(.DIV_W(DIV_W), .PAT_W(PAT_W)) bus ();

    tick_sequencer #(.DIV_W(DIV_W), .PAT_W(PAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        abort;
        logic [15:0] pattern;
        logic [4:0]  len;
        logic [27:0] div_max;
        logic        e_bo;
        logic        e_bv;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic        e_slow;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic a,
                                input logic [15:0] p, input logic [4:0] l,
                                input logic [27:0] d, input logic [5:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a;
        v.pattern = p; v.len = l; v.div_max = d;
        {v.e_bo, v.e_bv, v.e_busy, v.e_done, v.e_err, v.e_slow} = e;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic [15:0] p,
                         input logic [4:0] l, input logic [27:0] d);
        bus.start   = s;
        bus.abort   = a;
        bus.pattern = p;
        bus.len     = l;
        bus.div_max = d;
    endtask

    task automatic check_all(input string tag, input logic [5:0] e);
        check({tag, ".bit_out"},   bus.bit_out,   e[5]);
        check({tag, ".bit_valid"}, bus.bit_valid, e[4]);
        check({tag, ".busy"},      bus.busy,      e[3]);
        check({tag, ".done"},      bus.done,      e[2]);
        check({tag, ".err"},       bus.err,       e[1]);
        check({tag, ".slow_clk"},  bus.slow_clk,  e[0]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 5'd0, 28'd0);

        // Columns: rst start abort pattern len div | bo bv busy done err slow
        vecs[0]  = mk(0, 1, 0, 16'hB000, 5'd4,  28'd0, 6'b001000);
        vecs[1]  = mk(0, 0, 0, 16'h0000, 5'd0,  28'd5, 6'b111001);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 5'd0,  28'd5, 6'b011000);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 5'd0,  28'd5, 6'b111001);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 5'd0,  28'd5, 6'b110100);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 5'd0,  28'd5, 6'b100000);
        vecs[6]  = mk(0, 1, 0, 16'hFFFF, 5'd0,  28'd0, 6'b100010);
        vecs[7]  = mk(0, 0, 0, 16'hFFFF, 5'd0,  28'd0, 6'b100000);
        vecs[8]  = mk(0, 1, 0, 16'hFFFF, 5'd17, 28'd0, 6'b100010);
        vecs[9]  = mk(0, 0, 0, 16'hFFFF, 5'd17, 28'd0, 6'b100000);
        vecs[10] = mk(0, 0, 1, 16'hFFFF, 5'd4,  28'd0, 6'b100000);
        vecs[11] = mk(0, 1, 0, 16'h0000, 5'd1,  28'd0, 6'b101000);
        vecs[12] = mk(0, 1, 0, 16'h0000, 5'd1,  28'd0, 6'b010100);
        vecs[13] = mk(0, 1, 0, 16'h0000, 5'd1,  28'd0, 6'b001000);
        vecs[14] = mk(0, 1, 0, 16'h0000, 5'd1,  28'd0, 6'b010100);
        vecs[15] = mk(0, 0, 0, 16'h0000, 5'd1,  28'd0, 6'b000000);
        vecs[16] = mk(0, 1, 1, 16'hC000, 5'd2,  28'd0, 6'b001000);
        vecs[17] = mk(0, 1, 0, 16'hC000, 5'd2,  28'd0, 6'b111001);
        vecs[18] = mk(0, 0, 0, 16'hC000, 5'd2,  28'd0, 6'b110100);
        vecs[19] = mk(0, 0, 0, 16'hC000, 5'd2,  28'd0, 6'b100000);
        vecs[20] = mk(1, 1, 1, 16'hC000, 5'd2,  28'd0, 6'b000000);
        vecs[21] = mk(0, 0, 0, 16'h0000, 5'd0,  28'd0, 6'b000000);

        // Reset state.
        cyc();
        cyc();
        check_all("reset", 6'b000000);
        rst = 1'b0;

        // Table: inputs held for one cycle, outputs checked in the next.
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].start, vecs[i].abort, vecs[i].pattern, vecs[i].len, vecs[i].div_max);
            cyc();
            check_all($sformatf("vec%0d", i),
                      {vecs[i].e_bo, vecs[i].e_bv, vecs[i].e_busy,
                       vecs[i].e_done, vecs[i].e_err, vecs[i].e_slow});
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 5'd0, 28'd0);
        cyc();

        // D=3, two bits: valid in cycles 5 and 9; inputs scrambled after acceptance.
        drive(1'b1, 1'b0, 16'h8000, 5'd2, 28'd3);
        cyc();
        drive(1'b0, 1'b0, 16'h0000, 5'd0, 28'd0);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("d3.bv.c%0d", c),   bus.bit_valid, (c == 5) || (c == 9));
            check($sformatf("d3.busy.c%0d", c), bus.busy,      (c >= 1) && (c <= 8));
            check($sformatf("d3.done.c%0d", c), bus.done,      c == 9);
            check($sformatf("d3.slow.c%0d", c), bus.slow_clk,  (c >= 5) && (c <= 8));
            if (c == 5) check("d3.bit0", bus.bit_out, 1'b1);
            if (c == 9) check("d3.bit1", bus.bit_out, 1'b0);
            cyc();
        end

        // len=16, D=1, abort in cycle 7 between ticks.
        drive(1'b1, 1'b0, 16'hA5A5, 5'd16, 28'd1);
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("ab.bv.c%0d", c),   bus.bit_valid, (c == 3) || (c == 5) || (c == 7));
            check($sformatf("ab.busy.c%0d", c), bus.busy,      (c >= 1) && (c <= 7));
            check($sformatf("ab.done.c%0d", c), bus.done,      1'b0);
            check($sformatf("ab.slow.c%0d", c), bus.slow_clk,  (c == 3) || (c == 4) || (c == 7));
            if (c == 3) check("ab.bit0", bus.bit_out, 1'b1);
            if (c == 5) check("ab.bit1", bus.bit_out, 1'b0);
            if (c == 7) check("ab.bit2", bus.bit_out, 1'b1);
            if (c == 7) bus.abort = 1'b1;
            cyc();
            bus.abort = 1'b0;
        end

        // Abort coinciding with a tick (D=0, cycle 3): that tick emits nothing.
        drive(1'b1, 1'b0, 16'hF000, 5'd4, 28'd0);
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("at.bv.c%0d", c),   bus.bit_valid, (c == 2) || (c == 3));
            check($sformatf("at.busy.c%0d", c), bus.busy,      (c >= 1) && (c <= 3));
            check($sformatf("at.done.c%0d", c), bus.done,      1'b0);
            check($sformatf("at.slow.c%0d", c), bus.slow_clk,  c == 2);
            if (c == 3) bus.abort = 1'b1;
            cyc();
            bus.abort = 1'b0;
        end

        // Reset in cycle 4 of a len=8 D=0 run, restart in cycle 6 from bit 0.
        drive(1'b1, 1'b0, 16'hA000, 5'd8, 28'd0);
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("rs.bv.c%0d", c),   bus.bit_valid,
                  ((c >= 2) && (c <= 4)) || ((c >= 8) && (c <= 15)));
            check($sformatf("rs.busy.c%0d", c), bus.busy,
                  ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 14)));
            check($sformatf("rs.done.c%0d", c), bus.done, c == 15);
            check($sformatf("rs.err.c%0d", c),  bus.err,  1'b0);
            check($sformatf("rs.slow.c%0d", c), bus.slow_clk,
                  (c == 2) || (c == 4) || (c == 8) || (c == 10) || (c == 12) || (c == 14));
            if (c >= 2)
                check($sformatf("rs.bo.c%0d", c), bus.bit_out,
                      (c == 2) || (c == 4) || (c == 8) || (c == 10));
            if (c == 4) rst = 1'b1;
            if (c == 6) bus.start = 1'b1;
            cyc();
            rst       = 1'b0;
            bus.start = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
